// File: rtl/dmem_arbiter_pkg.sv
// Shared encodings for the data-memory arbiter: access sizes, response owner, defaults.
package dmem_arb_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b11;

  localparam int STARVE_LIMIT_DEF = 4;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_C    = 2'd1,
    OWN_D    = 2'd2
  } owner_e;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundle of the two requester ports and the data_memory side of the arbiter.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              c_req, c_we, c_gnt, c_stall, c_rvalid, c_err;
  logic [ADDR_W-1:0] c_addr;
  logic [DATA_W-1:0] c_wdata, c_rdata;
  logic [1:0]        c_size;

  logic              d_req, d_we, d_gnt, d_stall, d_rvalid, d_err;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata, d_rdata;
  logic [1:0]        d_size;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_re, mem_we;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
  logic [1:0]        mem_size;

  // arbiter side
  modport slave (
    input  c_req, c_we, c_addr, c_wdata, c_size,
    output c_gnt, c_stall, c_rvalid, c_err, c_rdata,
    input  d_req, d_we, d_addr, d_wdata, d_size,
    output d_gnt, d_stall, d_rvalid, d_err, d_rdata,
    output mem_addr, mem_re, mem_we, mem_wdata, mem_size,
    input  mem_rdata
  );

  // requester / memory side
  modport master (
    output c_req, c_we, c_addr, c_wdata, c_size,
    input  c_gnt, c_stall, c_rvalid, c_err, c_rdata,
    output d_req, d_we, d_addr, d_wdata, d_size,
    input  d_gnt, d_stall, d_rvalid, d_err, d_rdata,
    input  mem_addr, mem_re, mem_we, mem_wdata, mem_size,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_arbiter_align_check.sv
// Combinational alignment check for one memory command (reserved size always fails).
module dmem_align_check
  import dmem_arb_pkg::*;
(
  input  logic [1:0] addr,
  input  logic [1:0] size,
  output logic       misaligned
);
  always_comb begin
    misaligned = 1'b1;
    case (size)
      SZ_BYTE: misaligned = 1'b0;
      SZ_HALF: misaligned = addr[0];
      SZ_WORD: misaligned = |addr;
      default: misaligned = 1'b1;
    endcase
  end
endmodule

// File: rtl/dmem_arbiter.sv
// Core (C) / loader (D) arbiter in front of a single synchronous data_memory.
// C has priority; D wins once it has lost STARVE_LIMIT consecutive requesting cycles.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic          clock,
  input  logic          reset,
  dmem_arbiter_if.slave bus
);
  localparam int CW = $clog2(STARVE_LIMIT + 1);

  logic [CW-1:0]     starve_q, starve_d;
  owner_e            owner_q, owner_d;
  logic              err_q, err_d, rd_q, rd_d;

  logic              starved, c_gnt, d_gnt, gnt, mis;
  logic              win_we;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;
  logic [1:0]        win_size;
  logic              c_rsp, d_rsp;

  assign starved = (starve_q == CW'(STARVE_LIMIT));
  assign d_gnt   = ~reset & bus.d_req & (~bus.c_req | starved);
  assign c_gnt   = ~reset & bus.c_req & ~d_gnt;
  assign gnt     = c_gnt | d_gnt;

  // Winner mux; zeros when nobody is granted so the memory bus idles at 0.
  always_comb begin
    win_we    = 1'b0;
    win_addr  = '0;
    win_wdata = '0;
    win_size  = '0;
    if (d_gnt) begin
      win_we    = bus.d_we;
      win_addr  = bus.d_addr;
      win_wdata = bus.d_wdata;
      win_size  = bus.d_size;
    end else if (c_gnt) begin
      win_we    = bus.c_we;
      win_addr  = bus.c_addr;
      win_wdata = bus.c_wdata;
      win_size  = bus.c_size;
    end
  end

  dmem_align_check u_align (
    .addr       (win_addr[1:0]),
    .size       (win_size),
    .misaligned (mis)
  );

  assign bus.mem_addr  = win_addr;
  assign bus.mem_wdata = win_wdata;
  assign bus.mem_size  = win_size;
  assign bus.mem_re    = gnt & ~win_we & ~mis;
  assign bus.mem_we    = gnt &  win_we & ~mis;

  assign bus.c_gnt   = c_gnt;
  assign bus.d_gnt   = d_gnt;
  assign bus.c_stall = bus.c_req & ~c_gnt;
  assign bus.d_stall = bus.d_req & ~d_gnt;

  always_comb begin
    starve_d = starve_q;
    if (d_gnt)
      starve_d = '0;
    else if (bus.d_req && !starved)
      starve_d = starve_q + CW'(1);

    owner_d = OWN_NONE;
    if (d_gnt)      owner_d = OWN_D;
    else if (c_gnt) owner_d = OWN_C;
    err_d = gnt & mis;
    rd_d  = gnt & ~win_we;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      starve_q <= '0;
      owner_q  <= OWN_NONE;
      err_q    <= 1'b0;
      rd_q     <= 1'b0;
    end else begin
      starve_q <= starve_d;
      owner_q  <= owner_d;
      err_q    <= err_d;
      rd_q     <= rd_d;
    end
  end

  // A rejected read still returns rvalid, but with zero data.
  assign c_rsp        = (owner_q == OWN_C);
  assign d_rsp        = (owner_q == OWN_D);
  assign bus.c_rvalid = c_rsp & rd_q;
  assign bus.d_rvalid = d_rsp & rd_q;
  assign bus.c_err    = c_rsp & err_q;
  assign bus.d_err    = d_rsp & err_q;
  assign bus.c_rdata  = (c_rsp & rd_q & ~err_q) ? bus.mem_rdata : '0;
  assign bus.d_rdata  = (d_rsp & rd_q & ~err_q) ? bus.mem_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench: vector table plus corner sequences, responses via a scoreboard queue.
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  typedef struct packed {
    logic        req, we;
    logic [31:0] addr, wdata;
    logic [1:0]  size;
  } cmd_t;

  typedef struct packed {
    logic        c_rv, c_err;
    logic [31:0] c_rd;
    logic        d_rv, d_err;
    logic [31:0] d_rd;
  } resp_t;

  typedef struct packed {
    cmd_t        c, d;
    logic        egc, egd, ere, ewe;
    logic [31:0] eaddr;
    resp_t       r;
  } vec_t;

  logic  clk = 1'b0;
  logic  rst;
  int    ntests = 0, nfail = 0;
  resp_t sb[$];
  logic [31:0] memw [64];
  vec_t  tbl [15];

  dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();
  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // data_memory model: synchronous read, byte-lane writes; garbage when not reading
  always @(posedge clk) begin
    if (bus.mem_re) bus.mem_rdata <= memw[bus.mem_addr[7:2]];
    else            bus.mem_rdata <= 32'hBAD0_BAD0;
    if (bus.mem_we) begin
      case (bus.mem_size)
        SZ_WORD: memw[bus.mem_addr[7:2]] <= bus.mem_wdata;
        SZ_HALF: memw[bus.mem_addr[7:2]][{bus.mem_addr[1], 4'b0} +: 16] <= bus.mem_wdata[15:0];
        default: memw[bus.mem_addr[7:2]][{bus.mem_addr[1:0], 3'b0} +: 8] <= bus.mem_wdata[7:0];
      endcase
    end
  end

  function automatic cmd_t RQ(input logic we, input logic [31:0] a, input logic [1:0] sz,
                              input logic [31:0] wd);
    cmd_t c;
    c.req = 1'b1; c.we = we; c.addr = a; c.size = sz; c.wdata = wd;
    return c;
  endfunction

  function automatic resp_t RC(input logic rv, input logic er, input logic [31:0] rd);
    resp_t r = '0;
    r.c_rv = rv; r.c_err = er; r.c_rd = rd;
    return r;
  endfunction

  function automatic resp_t RD(input logic rv, input logic er, input logic [31:0] rd);
    resp_t r = '0;
    r.d_rv = rv; r.d_err = er; r.d_rd = rd;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input cmd_t c, input cmd_t d);
    bus.c_req = c.req; bus.c_we = c.we; bus.c_addr = c.addr; bus.c_wdata = c.wdata; bus.c_size = c.size;
    bus.d_req = d.req; bus.d_we = d.we; bus.d_addr = d.addr; bus.d_wdata = d.wdata; bus.d_size = d.size;
  endtask

  task automatic chk_resp(input string tag, input resp_t e);
    chk({tag, " c_rvalid"}, {31'd0, bus.c_rvalid}, {31'd0, e.c_rv});
    chk({tag, " c_err"},    {31'd0, bus.c_err},    {31'd0, e.c_err});
    chk({tag, " c_rdata"},  bus.c_rdata,           e.c_rd);
    chk({tag, " d_rvalid"}, {31'd0, bus.d_rvalid}, {31'd0, e.d_rv});
    chk({tag, " d_err"},    {31'd0, bus.d_err},    {31'd0, e.d_err});
    chk({tag, " d_rdata"},  bus.d_rdata,           e.d_rd);
  endtask

  // One cycle: drive after the edge, check combinational outputs and last cycle's response
  task automatic run_vec(input string tag, input vec_t v);
    resp_t e;
    @(posedge clk); #1;
    drive(v.c, v.d);
    @(negedge clk);
    chk({tag, " c_gnt"},   {31'd0, bus.c_gnt},   {31'd0, v.egc});
    chk({tag, " d_gnt"},   {31'd0, bus.d_gnt},   {31'd0, v.egd});
    chk({tag, " c_stall"}, {31'd0, bus.c_stall}, {31'd0, v.c.req & ~v.egc});
    chk({tag, " mem_re"},  {31'd0, bus.mem_re},  {31'd0, v.ere});
    chk({tag, " mem_we"},  {31'd0, bus.mem_we},  {31'd0, v.ewe});
    chk({tag, " mem_addr"}, bus.mem_addr, v.eaddr);
    e = (sb.size() != 0) ? sb.pop_front() : resp_t'('0);
    chk_resp(tag, e);
    sb.push_back(v.r);
  endtask

  initial begin
    automatic cmd_t NOP = '0;
    vec_t v;
    for (int k = 0; k < 64; k++) memw[k] = 32'h1000_0000 | k;
    memw[4] = 32'hDEAD_BEEF;

    //             C                                D                        gc gd re we addr    response
    tbl[0]  = '{RQ(0, 32'h10, SZ_WORD, 0),       NOP,                      1, 0, 1, 0, 32'h10, RC(1, 0, 32'hDEAD_BEEF)};
    tbl[1]  = '{RQ(0, 32'h00, SZ_WORD, 0),       NOP,                      1, 0, 1, 0, 32'h00, RC(1, 0, 32'h1000_0000)};
    tbl[2]  = '{NOP,                             RQ(0, 32'h04, SZ_WORD, 0), 0, 1, 1, 0, 32'h04, RD(1, 0, 32'h1000_0001)};
    tbl[3]  = '{RQ(1, 32'h08, SZ_WORD, 32'h1234_5678), NOP,               1, 0, 0, 1, 32'h08, '0};
    tbl[4]  = '{RQ(1, 32'h03, SZ_HALF, 32'hFFFF), NOP,                     1, 0, 0, 0, 32'h03, RC(0, 1, 0)};
    tbl[5]  = '{NOP,                             RQ(0, 32'h01, SZ_BYTE, 0), 0, 1, 1, 0, 32'h01, RD(1, 0, 32'h1000_0000)};
    tbl[6]  = '{NOP,                             RQ(0, 32'h00, 2'b10, 0),  0, 1, 0, 0, 32'h00, RD(1, 1, 0)};
    tbl[7]  = '{RQ(0, 32'h02, SZ_WORD, 0),       NOP,                      1, 0, 0, 0, 32'h02, RC(1, 1, 0)};
    tbl[8]  = '{NOP,                             NOP,                      0, 0, 0, 0, 32'h00, '0};
    tbl[9]  = '{RQ(0, 32'h00, SZ_WORD, 0),       RQ(0, 32'h04, SZ_WORD, 0), 1, 0, 1, 0, 32'h00, RC(1, 0, 32'h1000_0000)};
    tbl[10] = '{NOP,                             RQ(1, 32'h0C, SZ_WORD, 32'hCAFE_F00D), 0, 1, 0, 1, 32'h0C, '0};
    tbl[11] = '{RQ(0, 32'h02, SZ_HALF, 0),       NOP,                      1, 0, 1, 0, 32'h02, RC(1, 0, 32'h1000_0000)};
    tbl[12] = '{RQ(0, 32'h08, SZ_WORD, 0),       NOP,                      1, 0, 1, 0, 32'h08, RC(1, 0, 32'h1234_5678)};
    tbl[13] = '{NOP,                             RQ(0, 32'h0C, SZ_WORD, 0), 0, 1, 1, 0, 32'h0C, RD(1, 0, 32'hCAFE_F00D)};
    tbl[14] = '{NOP,                             NOP,                      0, 0, 0, 0, 32'h00, '0};

    // reset state, including grants forced low while requests are up
    rst = 1'b1;
    drive(NOP, NOP);
    @(negedge clk);
    chk("rst mem_re", {31'd0, bus.mem_re}, 32'd0);
    chk("rst mem_we", {31'd0, bus.mem_we}, 32'd0);
    chk("rst mem_addr", bus.mem_addr, 32'd0);
    chk_resp("rst", '0);
    drive(RQ(0, 32'h10, SZ_WORD, 0), RQ(0, 32'h04, SZ_WORD, 0));
    @(negedge clk);
    chk("rst c_gnt", {31'd0, bus.c_gnt}, 32'd0);
    chk("rst d_gnt", {31'd0, bus.d_gnt}, 32'd0);
    chk("rst mem_re req", {31'd0, bus.mem_re}, 32'd0);
    drive(NOP, NOP);
    @(posedge clk); #1 rst = 1'b0;

    for (int i = 0; i < 15; i++) run_vec($sformatf("vec%0d", i), tbl[i]);

    // reset in the cycle after a read grant discards the response
    run_vec("rstrd grant", tbl[0]);
    @(posedge clk); #1;
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    chk("rstrd c_rvalid", {31'd0, bus.c_rvalid}, 32'd0);
    chk("rstrd c_rdata", bus.c_rdata, 32'd0);
    chk("rstrd c_gnt", {31'd0, bus.c_gnt}, 32'd0);
    chk("rstrd mem_re", {31'd0, bus.mem_re}, 32'd0);
    chk("rstrd mem_addr", bus.mem_addr, 32'd0);
    drive(NOP, NOP);
    @(posedge clk); #1 rst = 1'b0;
    run_vec("rstrd idle", tbl[14]);

    // D alone for 10 cycles: granted every cycle, never builds starvation
    for (int i = 0; i < 10; i++) begin
      v = '0;
      v.d = RQ(0, 32'h20 + 32'(4 * i), SZ_WORD, 0);
      v.egd = 1'b1; v.ere = 1'b1; v.eaddr = 32'h20 + 32'(4 * i);
      v.r = RD(1, 0, 32'h1000_0008 + 32'(i));
      run_vec($sformatf("dalone%0d", i), v);
    end

    // both requesting continuously: D wins on cycles 4 and 9
    for (int i = 0; i < 10; i++) begin
      v = '0;
      v.c = RQ(0, 32'h00, SZ_WORD, 0);
      v.d = RQ(0, 32'h04, SZ_WORD, 0);
      v.ere = 1'b1;
      if (i == 4 || i == 9) begin
        v.egd = 1'b1; v.eaddr = 32'h04; v.r = RD(1, 0, 32'h1000_0001);
      end else begin
        v.egc = 1'b1; v.eaddr = 32'h00; v.r = RC(1, 0, 32'h1000_0000);
      end
      run_vec($sformatf("starve%0d", i), v);
    end
    run_vec("drain", tbl[14]);

    // the misaligned half write at 0x03 must not have touched memory
    chk("mem word0 intact", memw[0], 32'h1000_0000);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
